// File: rtl/mult_arbiter_if.sv
// rtl/mult_arbiter_if.sv - requester, shared-multiplier and response bus of mult_arbiter
interface mult_arbiter_if #(
    parameter int NUM_REQ = 4
);
    localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [32*NUM_REQ-1:0] req_a;
    logic [32*NUM_REQ-1:0] req_b;
    logic [31:0]           mult_a;
    logic [31:0]           mult_b;
    logic [63:0]           mult_p;
    logic                  rsp_valid;
    logic [IDW-1:0]        rsp_id;
    logic [63:0]           rsp_p;

    modport slave (
        input  req_valid, req_a, req_b, mult_p,
        output req_ready, mult_a, mult_b, rsp_valid, rsp_id, rsp_p
    );

    modport master (
        output req_valid, req_a, req_b, mult_p,
        input  req_ready, mult_a, mult_b, rsp_valid, rsp_id, rsp_p
    );
endinterface

// File: rtl/mult_arbiter.sv
// rtl/mult_arbiter.sv - round-robin share of one pipelined multiplier; MULT_ARB_FIXED_PRIO_EN selects fixed priority
module mult_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int LATENCY = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    output logic            busy,
    mult_arbiter_if.slave   bus
);
    localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic               gnt_found;
    logic [IDW-1:0]     gnt_idx;
    logic               grant;
    logic [LATENCY-1:0] sh_vld;
    logic [IDW-1:0]     sh_id [LATENCY];

`ifdef MULT_ARB_FIXED_PRIO_EN
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (bus.req_valid[k]) begin
                gnt_found = 1'b1;
                gnt_idx   = IDW'(k);
            end
        end
    end
`else
    logic [IDW-1:0] ptr;
    int             cand;

    // Walk upward from ptr with wrap; the first valid requester wins.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = int'(ptr) + k;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            if (!gnt_found && bus.req_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = IDW'(cand);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (grant) begin
            ptr <= (gnt_idx == IDW'(NUM_REQ - 1)) ? '0 : gnt_idx + IDW'(1);
        end
    end
`endif

    // rst_n is folded in so the combinational outputs are quiet during reset.
    assign grant = gnt_found && en && rst_n;

    always_comb begin
        bus.req_ready = '0;
        bus.mult_a    = '0;
        bus.mult_b    = '0;
        if (grant) begin
            bus.req_ready = NUM_REQ'(1) << gnt_idx;
            bus.mult_a    = bus.req_a[32*int'(gnt_idx) +: 32];
            bus.mult_b    = bus.req_b[32*int'(gnt_idx) +: 32];
        end
    end

    // Tracks each op alongside the multiplier stages; never stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_vld <= '0;
            for (int i = 0; i < LATENCY; i++) sh_id[i] <= '0;
        end else begin
            sh_vld[0] <= grant;
            sh_id[0]  <= grant ? gnt_idx : '0;
            for (int i = 1; i < LATENCY; i++) begin
                sh_vld[i] <= sh_vld[i-1];
                sh_id[i]  <= sh_id[i-1];
            end
        end
    end

    assign bus.rsp_valid = sh_vld[LATENCY-1];
    assign bus.rsp_id    = sh_vld[LATENCY-1] ? sh_id[LATENCY-1] : '0;
    assign bus.rsp_p     = bus.mult_p;
    assign busy          = |sh_vld;

endmodule

// File: tb/tb_mult_arbiter.sv
// tb/tb_mult_arbiter.sv - self-checking bench for mult_arbiter with a pipelined multiplier model
module tb_mult_arbiter;
    localparam int NUM_REQ = 4;
    localparam int LATENCY = 5;
`ifdef MULT_ARB_FIXED_PRIO_EN
    localparam bit FP = 1'b1;
`else
    localparam bit FP = 1'b0;
`endif

    logic clk;
    logic rst_n;
    logic en;
    logic busy;
    int   cyc;
    int   n_pass;
    int   n_total;

    mult_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

    mult_arbiter #(.NUM_REQ(NUM_REQ), .LATENCY(LATENCY)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .busy  (busy),
        .bus   (bus)
    );

    // Multiplier model: product of the grant-cycle operands shows up LATENCY cycles later.
    logic [63:0] pipe [LATENCY];
    always @(posedge clk) begin
        pipe[0] <= {32'd0, bus.mult_a} * {32'd0, bus.mult_b};
        for (int i = 1; i < LATENCY; i++) pipe[i] <= pipe[i-1];
    end
    assign bus.mult_p = pipe[LATENCY-1];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] opnd(input logic [127:0] v, input int i);
        return v[32*i +: 32];
    endfunction

    typedef struct {
        int          id;
        logic [63:0] p;
        int          due;
    } sb_t;
    sb_t exp_q[$];

    // Scoreboard: push on every accept, pop and compare on every response.
    always @(negedge clk) begin
        sb_t it;
        if (!rst_n) begin
            exp_q.delete();
            chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        end else begin
            if (bus.rsp_valid) begin
                if (exp_q.size() == 0) begin
                    chk("rsp_unexpected", 64'd1, 64'd0);
                end else begin
                    it = exp_q.pop_front();
                    chk("rsp_due", 64'(cyc), 64'(it.due));
                    chk("rsp_id", 64'(bus.rsp_id), 64'(it.id));
                    chk("rsp_p", bus.rsp_p, it.p);
                end
            end else begin
                chk("rsp_id_idle", 64'(bus.rsp_id), 64'd0);
                if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
                    chk("rsp_missing", 64'd0, 64'd1);
                    void'(exp_q.pop_front());
                end
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (bus.req_ready[i]) begin
                    it.id  = i;
                    it.p   = {32'd0, opnd(bus.req_a, i)} * {32'd0, opnd(bus.req_b, i)};
                    it.due = cyc + LATENCY;
                    exp_q.push_back(it);
                end
            end
        end
    end

    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_ready", 64'(bus.req_ready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_rsp_valid_now", 64'(bus.rsp_valid), 64'd0);
        chk("rst_mult_a", 64'(bus.mult_a), 64'd0);
        chk("rst_mult_b", 64'(bus.mult_b), 64'd0);
        step();
        step();
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic       en;
        logic [3:0] valid;
        logic [3:0] exp_rr;
        logic [3:0] exp_fp;
    } vec_t;

    vec_t vecs[$];
    logic [3:0] exp_rdy;
    logic [31:0] ea, eb;
    int mptr;
    int k;

    initial begin
        if ($urandom_range(0, 0) == 0) begin
            rst_n = 1'b0;
        end
        cyc = 0; n_pass = 0; n_total = 0;
        en = 1'b1;
        bus.req_valid = 4'hF;
        bus.req_a = {32'd4, 32'd3, 32'd2, 32'd1};
        bus.req_b = {32'd8, 32'd7, 32'd6, 32'd5};
        step();
        pulse_reset();

        // Single op from requester 2, response exactly LATENCY cycles later.
        bus.req_valid = 4'b0100;
        bus.req_a = {32'd0, 32'd7, 32'd0, 32'd0};
        bus.req_b = {32'd0, 32'd6, 32'd0, 32'd0};
        #1;
        chk("single_ready", 64'(bus.req_ready), 64'h4);
        chk("single_mult_a", 64'(bus.mult_a), 64'd7);
        chk("single_mult_b", 64'(bus.mult_b), 64'd6);
        for (int i = 1; i <= LATENCY; i++) begin
            step();
            bus.req_valid = 4'b0000;
            #1;
            chk("single_rsp_timing", 64'(bus.rsp_valid), 64'(i == LATENCY));
        end
        chk("single_rsp_id", 64'(bus.rsp_id), 64'd2);
        chk("single_rsp_p", bus.rsp_p, 64'd42);

        // Maximum operands from requester 1.
        step();
        bus.req_valid = 4'b0010;
        bus.req_a = {32'd0, 32'd0, 32'hFFFF_FFFF, 32'd0};
        bus.req_b = {32'd0, 32'd0, 32'hFFFF_FFFF, 32'd0};
        #1;
        chk("max_ready", 64'(bus.req_ready), 64'h2);
        for (int i = 1; i <= LATENCY; i++) begin
            step();
            bus.req_valid = 4'b0000;
        end
        #1;
        chk("max_rsp_valid", 64'(bus.rsp_valid), 64'd1);
        chk("max_rsp_id", 64'(bus.rsp_id), 64'd1);
        chk("max_rsp_p", bus.rsp_p, 64'hFFFF_FFFE_0000_0001);
        step();

        // Table: round-robin from reset, en gating mid-stream, assorted valid patterns.
        for (int i = 0; i < 10; i++)
            vecs.push_back('{1'b1, 4'hF, 4'(1 << (i % 4)), 4'h1});
        for (int i = 0; i < 3; i++)
            vecs.push_back('{1'b0, 4'hF, 4'h0, 4'h0});
        vecs.push_back('{1'b1, 4'hF,    4'h4, 4'h1});
        vecs.push_back('{1'b1, 4'b1010, 4'h8, 4'h2});
        vecs.push_back('{1'b1, 4'b0110, 4'h2, 4'h2});
        vecs.push_back('{1'b1, 4'b0011, 4'h1, 4'h1});
        vecs.push_back('{1'b1, 4'b0000, 4'h0, 4'h0});
        vecs.push_back('{1'b1, 4'b1001, 4'h8, 4'h1});
        vecs.push_back('{1'b0, 4'b1000, 4'h0, 4'h0});
        vecs.push_back('{1'b1, 4'hF,    4'h1, 4'h1});

        pulse_reset();
        foreach (vecs[i]) begin
            en = vecs[i].en;
            bus.req_valid = vecs[i].valid;
            bus.req_a = {$urandom, $urandom, $urandom, $urandom};
            bus.req_b = {$urandom, $urandom, $urandom, $urandom};
            #1;
            exp_rdy = FP ? vecs[i].exp_fp : vecs[i].exp_rr;
            ea = 32'd0; eb = 32'd0;
            for (int j = 0; j < NUM_REQ; j++) begin
                if (exp_rdy[j]) begin
                    ea = opnd(bus.req_a, j);
                    eb = opnd(bus.req_b, j);
                end
            end
            chk($sformatf("vec%0d_ready", i), 64'(bus.req_ready), 64'(exp_rdy));
            chk($sformatf("vec%0d_mult_a", i), 64'(bus.mult_a), 64'(ea));
            chk($sformatf("vec%0d_mult_b", i), 64'(bus.mult_b), 64'(eb));
            if (!vecs[i].en) chk($sformatf("vec%0d_busy", i), 64'(busy), 64'd1);
            step();
        end
        en = 1'b1;
        bus.req_valid = 4'h0;
        for (int i = 0; i <= LATENCY; i++) step();
        chk("table_drain_busy", 64'(busy), 64'd0);
        chk("table_drain_queue", 64'(exp_q.size()), 64'd0);

        // Reset with three ops in flight: they must never come back.
        bus.req_valid = 4'b0110;
        for (int i = 0; i < 3; i++) step();
        bus.req_valid = 4'h0;
        step();
        step();
        chk("midrst_busy_before", 64'(busy), 64'd1);
        bus.req_valid = 4'hF;
        pulse_reset();
        #1;
        chk("midrst_first_grant", 64'(bus.req_ready), 64'h1);
        step();
        bus.req_valid = 4'h0;
        for (int i = 0; i < LATENCY + 3; i++) step();
        chk("midrst_busy_after", 64'(busy), 64'd0);
        chk("midrst_queue", 64'(exp_q.size()), 64'd0);

        // Random stress against an independent arbitration model.
        mptr = FP ? 0 : 1;
        for (int c = 0; c < 2000; c++) begin
            en = ($urandom_range(0, 7) != 0);
            bus.req_valid = 4'($urandom_range(0, 15));
            bus.req_a = {$urandom, $urandom, $urandom, $urandom};
            bus.req_b = {$urandom, $urandom, $urandom, $urandom};
            if (c % 97 == 0) begin
                bus.req_a[63:32] = 32'hFFFF_FFFF;
                bus.req_b[63:32] = 32'hFFFF_FFFF;
            end
            #1;
            exp_rdy = 4'h0;
            if (en) begin
                for (int j = 0; j < NUM_REQ; j++) begin
                    k = (mptr + j) % NUM_REQ;
                    if (exp_rdy == 4'h0 && bus.req_valid[k]) exp_rdy = 4'(1 << k);
                end
                if (exp_rdy != 4'h0 && !FP) begin
                    for (int j = 0; j < NUM_REQ; j++)
                        if (exp_rdy[j]) mptr = (j + 1) % NUM_REQ;
                end
            end
            chk("stress_ready", 64'(bus.req_ready), 64'(exp_rdy));
            step();
        end
        bus.req_valid = 4'h0;
        for (int i = 0; i <= LATENCY; i++) step();
        chk("stress_drain_busy", 64'(busy), 64'd0);
        chk("stress_drain_queue", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/mult_arbiter.md
MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters sharing one multiplier (2..8).
REQ-002 SHALL have parameter LATENCY, default 5, multiplier register stages from operand capture to product.
REQ-003 SHALL have port clk  input  1  single clock; all state on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port en  input  1  grant enable; low blocks new grants, in-flight ops still drain.
REQ-006 SHALL have port req_valid  input  NUM_REQ  per-requester operand valid.
REQ-007 SHALL have port req_ready  output  NUM_REQ  per-requester grant, one-hot or zero.
REQ-008 SHALL have port req_a  input  32*NUM_REQ  unsigned multiplicand, requester i at bits [32i+31:32i].
REQ-009 SHALL have port req_b  input  32*NUM_REQ  unsigned multiplier, same packing.
REQ-010 SHALL have port mult_a  output  32  operand A to the shared pipelined multiplier.
REQ-011 SHALL have port mult_b  output  32  operand B to the shared pipelined multiplier.
REQ-012 SHALL have port mult_p  input  64  product from the shared multiplier.
REQ-013 SHALL have port rsp_valid  output  1  result valid, single-cycle pulse per op, no backpressure.
REQ-014 SHALL have port rsp_id  output  clog2(NUM_REQ)  requester index owning rsp_p.
REQ-015 SHALL have port rsp_p  output  64  product, equal to mult_p.
REQ-016 SHALL have port busy  output  1  high while any op is in flight.

Function
REQ-017 SHALL assert at most one req_ready bit per cycle, only when en=1 and that requester's req_valid=1; req_ready is combinational from req_valid, en, and the priority pointer.
REQ-018 SHALL select the grant round-robin: search from pointer ptr upward with wrap at NUM_REQ-1 -> 0; the first valid requester wins.
REQ-019 SHALL set ptr to (g+1) mod NUM_REQ at the edge ending a cycle that grants requester g; ptr holds when there is no grant.
REQ-020 SHALL drive mult_a/mult_b from the granted requester's operands in the grant cycle, and drive 0/0 when there is no grant.
REQ-021 SHALL accept one op per cycle (full throughput); an accepted op is a cycle with req_valid[g]=req_ready[g]=1.
REQ-022 SHALL track in-flight ops in a LATENCY-deep valid+id shift register advancing every cycle, with no stall.
REQ-023 SHALL assert rsp_valid exactly LATENCY cycles after the accept cycle (accept in cycle t -> rsp_valid in cycle t+LATENCY), with rsp_id=g and rsp_p=mult_p.
REQ-024 SHALL drive rsp_id=0 when rsp_valid=0; rsp_p always equals mult_p.
REQ-025 SHALL set busy = OR of all shift-register valid bits.
REQ-026 SHALL, when en is deasserted, grant nothing that cycle while in-flight ops keep draining and returning normally.
REQ-027 SHALL leave req_valid with no grant unaffected; requesters hold operands until granted. The arbiter keeps no operand storage.

Reset
REQ-028 SHALL, while rst_n=0, immediately force ptr=0, all shift-register valid bits=0, all id bits=0, rsp_valid=0, rsp_id=0, busy=0, req_ready=0, mult_a=0, mult_b=0.
REQ-029 SHALL discard in-flight ops on reset mid-operation: no rsp_valid for them after release, even though the multiplier still emits products.
REQ-030 SHALL allow a grant in the first cycle after rst_n rises.

Configuration
REQ-031 SHALL, with macro MULT_ARB_FIXED_PRIO_EN defined, use fixed priority: the lowest-index valid requester wins and ptr is not implemented.
REQ-032 SHALL, without MULT_ARB_FIXED_PRIO_EN, use round-robin per REQ-018/019.

Verification
REQ-033 SHALL check a single op: requester 2 valid with a=7, b=6, en=1, all others idle -> req_ready=4'b0100 in that cycle; rsp_valid, rsp_id=2, rsp_p=42 exactly 5 cycles later.
REQ-034 SHALL check round-robin: all 4 requesters valid continuously from reset for 8 cycles -> grant order 0,1,2,3,0,1,2,3, and 8 consecutive rsp_valid pulses with matching ids (fixed-priority build: 0 every cycle).
REQ-035 SHALL check max operands: requester 1 with a=b=32'hFFFFFFFF -> rsp_p=64'hFFFFFFFE00000001, rsp_id=1.
REQ-036 SHALL check en gating: all valid, en low for 3 cycles mid-stream -> req_ready=0 for those 3 cycles, busy stays high until the last prior op returns, no rsp gaps before that point, ptr unchanged.
REQ-037 SHALL check reset mid-flight: 3 ops accepted, then rst_n pulsed low 2 cycles later -> no rsp_valid afterwards, busy=0, and the next grant goes to requester 0.
REQ-038 SHALL check random stress: 2000 cycles of random req_valid/operands against a scoreboard -> every accepted op returns exactly once, in order, with correct id and product.
